// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with optional return-address stack.
//
// Holds the fetch PC and picks the next PC by priority:
//   trap > redirect > RAS return hit > sequential (or hold on stall).
// Trap and redirect update the PC even while PCWrite is low.
//
// Optional feature macro: PC_RAS_EN
//   defined   : circular RAS (RAS_DEPTH entries) supplies return predictions
//   undefined : no RAS; call/ret ignored, ras_valid/ras_count tied to 0
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   PCWrite      fetch advance enable (0 = stall)
//   trap         exception/interrupt, loads TRAP_VEC and flushes the RAS
//   redirect     resolved taken branch/jump
//   redirect_pc  redirect target (forced word aligned)
//   call         resolved call, pushes link_addr
//   link_addr    return address to push
//   ret          decoded return, requests a RAS prediction
//   pc           current fetch PC
//   pc_plus4     pc + 4 (modulo 2^W)
//   ras_valid    RAS holds at least one entry
//   ras_count    number of valid RAS entries

module pc_unit #(
    parameter int unsigned W         = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         PCWrite,
    input  logic                         trap,
    input  logic                         redirect,
    input  logic [W-1:0]                 redirect_pc,
    input  logic                         call,
    input  logic [W-1:0]                 link_addr,
    input  logic                         ret,
    output logic [W-1:0]                 pc,
    output logic [W-1:0]                 pc_plus4,
    output logic                         ras_valid,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam logic [W-1:0] RESET_PC = W'(RESET_VEC);
    localparam logic [W-1:0] TRAP_PC  = W'(TRAP_VEC);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;
    logic         pop_c;
    logic [W-1:0] ras_top_c;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + W'(4);

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [W-1:0]     ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [PTR_W-1:0] top_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             push_c;
    logic             we_c;
    logic [PTR_W-1:0] waddr_c;

    assign push_c    = call & ~trap;
    assign pop_c     = ret & PCWrite & ras_valid & ~trap & ~redirect;
    assign ras_top_c = ras_mem[top_q];
    assign ras_valid = (cnt_q != '0);
    assign ras_count = cnt_q;

    // RAS pointer/count next state; a push when full wraps onto the oldest entry
    always_comb begin
        top_d   = top_q;
        cnt_d   = cnt_q;
        we_c    = 1'b0;
        waddr_c = top_q;
        if (trap) begin
            top_d = '0;
            cnt_d = '0;
        end else if (push_c && pop_c) begin
            // Return consumes the old top, the call replaces it in place
            we_c    = 1'b1;
            waddr_c = top_q;
        end else if (push_c) begin
            we_c    = 1'b1;
            waddr_c = top_q + PTR_W'(1);
            top_d   = top_q + PTR_W'(1);
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_c) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // RAS pointer and count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // RAS storage; contents need no reset because the count gates their use
    always_ff @(posedge clk) begin
        if (we_c) begin
            ras_mem[waddr_c] <= link_addr;
        end
    end
`else
    logic unused_ras_in;

    assign unused_ras_in = ^{call, link_addr, ret};
    assign pop_c         = 1'b0;
    assign ras_top_c     = '0;
    assign ras_valid     = 1'b0;
    assign ras_count     = '0;
`endif

    // Next-PC select
    always_comb begin
        pc_d = pc_q;
        if (trap) begin
            pc_d = TRAP_PC;
        end else if (redirect) begin
            pc_d = {redirect_pc[W-1:2], 2'b00};
        end else if (pop_c) begin
            pc_d = ras_top_c;
        end else if (PCWrite) begin
            pc_d = pc_plus4;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (default parameters). A reference model
// predicts pc and RAS occupancy each cycle; predictions are queued when the
// inputs are driven and compared after the following rising edge.

module tb_pc_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite;
    logic        trap;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        call;
    logic [31:0] link_addr;
    logic        ret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ras_valid;
    logic [2:0]  ras_count;

    typedef struct {
        logic [31:0] pc;
        int unsigned cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    int          n_checks = 0;
    int          n_errors = 0;

    pc_unit dut (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .trap        (trap),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .call        (call),
        .link_addr   (link_addr),
        .ret         (ret),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .ras_valid   (ras_valid),
        .ras_count   (ras_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        PCWrite     = 1'b0;
        trap        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        call        = 1'b0;
        link_addr   = 32'h0;
        ret         = 1'b0;
    endtask

    // Pop one prediction and compare against the DUT outputs
    task automatic compare();
        exp_t e;
        check("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("pc", pc, e.pc);
            check("pc_plus4", pc_plus4, e.pc + 32'd4);
            check("ras_count", 32'(ras_count), 32'(e.cnt));
            check("ras_valid", 32'(ras_valid), (e.cnt != 0) ? 32'd1 : 32'd0);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), predict, then check
    task automatic step(input logic pcw, input logic tr, input logic rd,
                        input logic [31:0] rpc, input logic cl,
                        input logic [31:0] la, input logic rt);
        exp_t        e;
        logic        hit;
        logic [31:0] nxt;
        PCWrite     = pcw;
        trap        = tr;
        redirect    = rd;
        redirect_pc = rpc;
        call        = cl;
        link_addr   = la;
        ret         = rt;
        hit = 1'b0;
`ifdef PC_RAS_EN
        hit = rt && pcw && !tr && !rd && (m_stk.size() != 0);
`endif
        if (tr)        nxt = 32'h0000_0100;
        else if (rd)   nxt = {rpc[31:2], 2'b00};
        else if (hit)  nxt = m_stk[$];
        else if (pcw)  nxt = m_pc + 32'd4;
        else           nxt = m_pc;
`ifdef PC_RAS_EN
        if (tr) begin
            m_stk.delete();
        end else begin
            if (hit) void'(m_stk.pop_back());
            if (cl) begin
                if (m_stk.size() == DEPTH) void'(m_stk.pop_front());
                m_stk.push_back(la);
            end
        end
`endif
        m_pc  = nxt;
        e.pc  = nxt;
        e.cnt = m_stk.size();
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare();
        @(negedge clk);
        idle();
    endtask

    // Assert reset between edges and expect the reset state without a clock
    task automatic do_reset();
        idle();
        rst = 1'b0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_ras_count", 32'(ras_count), 32'd0);
        check("rst_ras_valid", 32'(ras_valid), 32'd0);
        m_pc = 32'h0;
        m_stk.delete();
        sb_q.delete();
        @(posedge clk);
        #1;
        check("rst_hold_pc", pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        do_reset();

        // Sequential fetch, then reset mid-run at pc=0x8
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("seq_pc8", pc, 32'h8);
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);

        // Stall at 0xC, then redirect under stall
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h203, 0, 0, 0);
        check("redir_align", pc, 32'h200);

        // Call alongside a redirect, then return
        step(1, 0, 1, 32'h80, 1, 32'h14, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);

        // Trap beats redirect and flushes a two-entry RAS
        step(0, 0, 0, 0, 1, 32'h30, 0);
        step(0, 0, 0, 0, 1, 32'h40, 0);
        step(1, 1, 1, 32'h80, 1, 32'h44, 1);
        check("trap_pc", pc, 32'h100);

        // Overflow then underflow
        for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 1, 32'(i * 16), 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 1);

        // Simultaneous push and pop with two entries
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h30, 0);
        step(1, 0, 0, 0, 1, 32'h40, 0);
        step(1, 0, 0, 0, 1, 32'h90, 1);
        step(1, 0, 0, 0, 0, 0, 1);

        // ret under stall and ret under redirect must not pop
        step(1, 0, 0, 0, 1, 32'h60, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 32'h3F1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 120; i++) begin
            step(($urandom_range(3) != 0),
                 ($urandom_range(15) == 0),
                 ($urandom_range(7) == 0),
                 32'($urandom_range(4095)),
                 ($urandom_range(3) == 0),
                 32'($urandom),
                 ($urandom_range(2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage. It holds the fetch PC and selects the next PC from trap vector, resolved redirect, predicted return or sequential increment. An optional circular return-address stack (RAS) supplies return predictions. It replaces the bare enable-gated PC register and feeds the instruction-memory address and the IF/ID pipeline register.

## Interface
- W, 32, PC width in bits (≥8)
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (low W bits used)
- TRAP_VEC, 32'h0000_0100, PC value loaded on trap (low W bits used)
- RAS_DEPTH, 4, RAS entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- PCWrite  in  1  fetch advance enable; 0 = stall
- trap  in  1  exception/interrupt; forces TRAP_VEC
- redirect  in  1  resolved branch/jump taken
- redirect_pc  in  W  redirect target
- call  in  1  resolved call; push link_addr
- link_addr  in  W  return address to push
- ret  in  1  decoded return; request RAS prediction
- pc  out  W  current fetch PC
- pc_plus4  out  W  pc + 4, modulo 2^W
- ras_valid  out  1  RAS non-empty
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

## Operation
- Next-PC priority: trap > redirect > ret-hit > sequential.
  - trap=1: next pc = TRAP_VEC. RAS is flushed to empty. call and ret are ignored.
  - redirect=1: next pc = {redirect_pc[W-1:2],2'b00}. ret is ignored.
  - ret-hit (ret=1, PCWrite=1, ras_valid=1, no trap/redirect): next pc = RAS top; pop.
  - ret with RAS empty: treated as sequential; no pop.
  - Sequential: when PCWrite=1, next pc = pc_plus4; when PCWrite=0, pc holds.
- trap and redirect update pc even when PCWrite=0 (flush dominates stall).
- Push: call=1 with trap=0 writes link_addr at top+1, independent of PCWrite and redirect.
- Push when full: the oldest entry is overwritten, the top pointer wraps, and ras_count saturates at RAS_DEPTH.
- Accepted push and pop in the same cycle: the top entry is replaced with link_addr; ras_count is unchanged. The returned pc is the old top.
- Pointer arithmetic is modulo RAS_DEPTH. There is no RAS repair on redirect.

## Timing
- Reset (rst=0, asynchronous): pc=RESET_VEC, pc_plus4=RESET_VEC+4, ras_count=0, ras_valid=0, top pointer=0. Entry contents are don't-care.
- On the first rising edge after rst deasserts, normal update applies.
- Next pc and RAS top are combinational from current inputs. All state updates on the rising clk edge, so latency is 1 cycle from input to pc.
- pc_plus4, ras_valid and ras_count are combinational from registered state only.
- If rst asserts mid-cycle, it dominates any pending push, pop or redirect.

## Configuration
- PC_RAS_EN defined: RAS storage, pointer and count are built as above.
- PC_RAS_EN undefined: no RAS storage. ret is ignored (sequential), call is ignored, and ras_valid and ras_count are tied to 0. Trap, redirect and stall behaviour is unchanged.

## Test plan
- Reset/sequential: hold rst=0, release with PCWrite=1 → pc 0x0, 0x4, 0x8. Assert rst mid-run at pc=0x8 → pc=0x0 immediately, without waiting for a clock edge.
- Stall then redirect: PCWrite=0 for 3 cycles at pc=0xC → pc stays 0xC. Then redirect=1, redirect_pc=0x203 with PCWrite=0 → pc=0x200 next cycle.
- Priority: trap=1, redirect=1, redirect_pc=0x80, with ras_count=2 → pc=0x100, ras_count=0.
- Call/return: call=1, link_addr=0x14, redirect=1, redirect_pc=0x80 → pc=0x80, ras_count=1. Later ret=1, PCWrite=1 → pc=0x14, ras_count=0.
- Overflow/underflow (RAS_DEPTH=4): push 0x10, 0x20, 0x30, 0x40, 0x50 → ras_count=4. Four ret → pc 0x50, 0x40, 0x30, 0x20. Fifth ret at pc=X → pc=X+4.
- Simultaneous push and pop with ras_count=2, top=0x40: call=1, link_addr=0x90, ret=1 → pc=0x40, ras_count=2. Next ret → pc=0x90. Repeat the ret test built without PC_RAS_EN → pc=pc+4, ras_valid=0.
